// File: rtl/pool_pkg.sv
// pool_pkg: pixel types and constants shared by the 2x2 pooling stages.
package pool_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int OUT_CHANNELS = 8;
  typedef logic signed [DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [OUT_CHANNELS-1:0] pixel_vec_t;
  typedef struct packed {
    pixel_vec_t p0;
    pixel_vec_t p1;
  } pixel_pair_t;
  localparam pixel_t PIX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam pixel_vec_t VEC_MIN = {OUT_CHANNELS{PIX_MIN}};
endpackage

// File: rtl/pool_window_buffer_if.sv
// pool_window_buffer_if: raster pixel stream in, 2x2 window out.
interface pool_window_buffer_if;
  import pool_pkg::*;
  logic valid_in;
  logic sof;
  pixel_vec_t pixel_in;
  pixel_vec_t pixel_00;
  pixel_vec_t pixel_01;
  pixel_vec_t pixel_10;
  pixel_vec_t pixel_11;
  logic valid_out;
  logic frame_done;
  modport master(output valid_in, sof, pixel_in,
                 input pixel_00, pixel_01, pixel_10, pixel_11, valid_out, frame_done);
  modport slave(input valid_in, sof, pixel_in,
                output pixel_00, pixel_01, pixel_10, pixel_11, valid_out, frame_done);
endinterface

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one row of pixel pairs, single write port, asynchronous read, no reset.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pixel_pair_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output pixel_pair_t rd_data
);
  pixel_pair_t mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pool_window_buffer.sv
// pool_window_buffer: assembles stride-2 2x2 windows from a raster pixel stream.
// POOL_EDGE_PAD_EN pads odd-size right/bottom edges with PIX_MIN instead of dropping them.
module pool_window_buffer
  import pool_pkg::*;
#(
  parameter int IMG_WIDTH = 32,
  parameter int IMG_HEIGHT = 32
) (
  input logic clk,
  input logic rst,
  pool_window_buffer_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
`ifdef POOL_EDGE_PAD_EN
  localparam int DEPTH = (IMG_WIDTH + 1) / 2;
  localparam int LAST_C = IMG_WIDTH - 1;
  localparam int LAST_R = IMG_HEIGHT - 1;
`else
  localparam int DEPTH = IMG_WIDTH / 2;
  localparam int LAST_C = 2 * (IMG_WIDTH / 2) - 1;
  localparam int LAST_R = 2 * (IMG_HEIGHT / 2) - 1;
`endif
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [CW-1:0] col, c;
  logic [RW-1:0] row, r;
  logic c_wrap, c_end, tail, emit, wr_en;
  pixel_vec_t prev;
  pixel_pair_t cur, rd_pair, top, bot;
  always_comb begin
    c = (bus.valid_in & bus.sof) ? '0 : col;
    r = (bus.valid_in & bus.sof) ? '0 : row;
    c_wrap = c == CW'(IMG_WIDTH - 1);
`ifdef POOL_EDGE_PAD_EN
    c_end = c[0] | c_wrap;
    tail = (IMG_HEIGHT % 2 == 1) && (r == RW'(IMG_HEIGHT - 1));
    cur = c[0] ? {prev, bus.pixel_in} : {bus.pixel_in, VEC_MIN};
`else
    c_end = c[0];
    tail = 1'b0;
    cur = {prev, bus.pixel_in};
`endif
    emit = bus.valid_in & c_end & (r[0] | tail);
    wr_en = bus.valid_in & c_end & ~r[0];
    top = tail ? cur : rd_pair;
    bot = tail ? {VEC_MIN, VEC_MIN} : cur;
  end
  // even rows store pairs; the odd row reads them back in the same cycle it completes a window
  pool_line_buffer #(.DEPTH(DEPTH), .AW(AW)) u_line (
    .clk(clk),
    .wr_en(wr_en),
    .wr_addr(AW'(c >> 1)),
    .wr_data(cur),
    .rd_addr(AW'(c >> 1)),
    .rd_data(rd_pair)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col <= '0;
      row <= '0;
      prev <= '0;
      bus.valid_out <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.pixel_00 <= '0;
      bus.pixel_01 <= '0;
      bus.pixel_10 <= '0;
      bus.pixel_11 <= '0;
    end else begin
      bus.valid_out <= emit;
      bus.frame_done <= emit && c == CW'(LAST_C) && r == RW'(LAST_R);
      if (bus.valid_in) begin
        col <= c_wrap ? '0 : c + 1'b1;
        row <= c_wrap ? (r == RW'(IMG_HEIGHT - 1) ? '0 : r + 1'b1) : r;
        if (!c[0]) prev <= bus.pixel_in;
      end
      if (emit) begin
        bus.pixel_00 <= top.p0;
        bus.pixel_01 <= top.p1;
        bus.pixel_10 <= bot.p0;
        bus.pixel_11 <= bot.p1;
      end
    end
endmodule

// File: tb/tb_pool_window_buffer.sv
// tb_pool_window_buffer: scoreboard bench for a 4x4 and a 5x3 window buffer.
module tb_pool_window_buffer;
  import pool_pkg::*;
  typedef logic [4*OUT_CHANNELS*DATA_WIDTH:0] win_t;
  typedef struct {
    win_t w;
    int cyc;
  } exp_t;
  localparam int MN = 32'h7fff_ffff;
  logic clk = 0;
  logic rst = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q53[$];
  pool_window_buffer_if b4();
  pool_window_buffer_if b53();
  pool_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  pool_window_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) u53 (.clk(clk), .rst(rst), .bus(b53));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input win_t got, input win_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic pixel_vec_t vec(input int v);
    pixel_vec_t p;
    for (int i = 0; i < OUT_CHANNELS; i++) p[i] = (v == MN) ? PIX_MIN : pixel_t'(v + i);
    return p;
  endfunction
  function automatic win_t win(input int a, input int b, input int c, input int d, input bit done);
    return {done, vec(a), vec(b), vec(c), vec(d)};
  endfunction
  always @(negedge clk) if (rst) begin : mon4
    exp_t e;
    if (b4.valid_out) begin
      if (q4.size() == 0) check("extra4", 1, 0);
      else begin
        e = q4.pop_front();
        check("win4", {b4.frame_done, b4.pixel_00, b4.pixel_01, b4.pixel_10, b4.pixel_11}, e.w);
        check("lat4", cyc, e.cyc);
      end
    end else if (b4.frame_done) check("stray_fd4", 1, 0);
  end
  always @(negedge clk) if (rst) begin : mon53
    exp_t e;
    if (b53.valid_out) begin
      if (q53.size() == 0) check("extra53", 1, 0);
      else begin
        e = q53.pop_front();
        check("win53", {b53.frame_done, b53.pixel_00, b53.pixel_01, b53.pixel_10, b53.pixel_11}, e.w);
        check("lat53", cyc, e.cyc);
      end
    end else if (b53.frame_done) check("stray_fd53", 1, 0);
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      b4.valid_in = 0;
      b4.sof = 0;
      b53.valid_in = 0;
      b53.sof = 0;
    end
  endtask
  task automatic drv4(input bit s, input int v);
    @(posedge clk);
    #1;
    b4.valid_in = 1;
    b4.sof = s;
    b4.pixel_in = vec(v);
  endtask
  // pixel i of a 4-wide ramp frame has value base+i; odd row & odd col completes a window
  task automatic frame4(input int base, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      drv4(i == 0, base + i);
      if ((i / 4) % 2 == 1 && (i % 4) % 2 == 1)
        q4.push_back('{win(base + i - 5, base + i - 4, base + i - 1, base + i, i == 15), cyc + 1});
      if (rnd) idle($urandom_range(0, 2));
    end
  endtask
  task automatic frame53();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      b53.valid_in = 1;
      b53.sof = (i == 0);
      b53.pixel_in = vec(i);
`ifdef POOL_EDGE_PAD_EN
      case (i)
        6: q53.push_back('{win(0, 1, 5, 6, 0), cyc + 1});
        8: q53.push_back('{win(2, 3, 7, 8, 0), cyc + 1});
        9: q53.push_back('{win(4, MN, 9, MN, 0), cyc + 1});
        11: q53.push_back('{win(10, 11, MN, MN, 0), cyc + 1});
        13: q53.push_back('{win(12, 13, MN, MN, 0), cyc + 1});
        14: q53.push_back('{win(14, MN, MN, MN, 1), cyc + 1});
        default: ;
      endcase
`else
      case (i)
        6: q53.push_back('{win(0, 1, 5, 6, 0), cyc + 1});
        8: q53.push_back('{win(2, 3, 7, 8, 1), cyc + 1});
        default: ;
      endcase
`endif
    end
  endtask
  initial begin
    b4.valid_in = 0;
    b4.sof = 0;
    b4.pixel_in = '0;
    b53.valid_in = 0;
    b53.sof = 0;
    b53.pixel_in = '0;
    #12;
    check("rst_vo", b4.valid_out, 0);
    check("rst_out", {b4.frame_done, b4.pixel_00, b4.pixel_01, b4.pixel_10, b4.pixel_11}, '0);
    @(negedge clk) rst = 1;
    frame4(0, 16, 0);
    idle(3);
    frame4(0, 16, 1);
    idle(3);
    frame4(-30, 16, 0);
    idle(3);
    frame4(50, 6, 0);
    frame4(60, 16, 0);
    idle(3);
    frame4(100, 9, 0);
    drv4(0, 109);
    #2;
    rst = 0;
    b4.valid_in = 0;
    b4.sof = 0;
    #1;
    check("arst_vo", b4.valid_out, 0);
    check("arst_out", {b4.frame_done, b4.pixel_00, b4.pixel_01, b4.pixel_10, b4.pixel_11}, '0);
    @(negedge clk);
    @(negedge clk) rst = 1;
    frame4(200, 16, 0);
    idle(3);
    frame53();
    idle(4);
    check("drain4", q4.size(), 0);
    check("drain53", q53.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
